// File: rtl/md_unit_iter.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers.
// Each op takes 32 shift-add or restoring-divide steps, then one sign-fixup cycle.
module md_unit_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] mcand_q, mcand_d;
    logic        is_div_q, is_div_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        busy_q, busy_d, done_q, done_d;

    logic        is_signed;
    logic [31:0] a_mag, b_mag;
    logic [32:0] add_sum;
    logic [32:0] div_diff;
    logic        div_ok;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;

    assign is_signed = ~op[0];
    assign a_mag     = (is_signed && a[31]) ? (~a + 32'd1) : a;
    assign b_mag     = (is_signed && b[31]) ? (~b + 32'd1) : b;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    assign add_sum  = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? mcand_q : 32'h0)};
    // Divide: acc = {remainder, dividend/quotient}, shifted left each step.
    assign div_ok   = acc_q[63:31] >= {1'b0, mcand_q};
    assign div_diff = acc_q[63:31] - {1'b0, mcand_q};

    assign prod_fix = neg_quo_q ? (~acc_q + 64'd1) : acc_q;
    assign quo_fix  = neg_quo_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    assign rem_fix  = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        is_div_d  = is_div_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && !cancel) begin
                    if (!op[2]) begin
                        is_div_d  = op[1];
                        acc_d     = {32'h0, (op[1] ? a_mag : b_mag)};
                        mcand_d   = op[1] ? b_mag : a_mag;
                        // Divide by zero keeps an all-ones quotient regardless of sign.
                        neg_quo_d = is_signed & (a[31] ^ b[31]) & ~(op[1] & (b == 32'h0));
                        neg_rem_d = is_signed & a[31];
                        cnt_d     = 5'd0;
                        busy_d    = 1'b1;
                        state_d   = StRun;
                    end else if (op == 3'd4) begin
                        hi_d = a;
                    end else if (op == 3'd5) begin
                        lo_d = a;
                    end
                end
            end
            StRun: begin
                if (cancel) begin
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    if (is_div_q) begin
                        acc_d = div_ok ? {div_diff[31:0], acc_q[30:0], 1'b1}
                                       : {acc_q[62:0], 1'b0};
                    end else begin
                        acc_d = {add_sum, acc_q[31:1]};
                    end
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_d = StFix;
                end
            end
            StFix: begin
                busy_d  = 1'b0;
                state_d = StIdle;
                if (!cancel) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[63:32];
                        lo_d = prod_fix[31:0];
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= 5'd0;
            acc_q     <= 64'h0;
            mcand_q   <= 32'h0;
            is_div_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= 32'h0;
            lo_q      <= 32'h0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            is_div_q  <= is_div_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit_iter.sv
// Self-checking bench for md_unit_iter: directed plan vectors, random ops against an
// arithmetic reference model, MTHI/MTLO, cancel, ignored start and async reset.
module tb_md_unit_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'h0;
    logic [31:0] b = 32'h0;
    logic        cancel = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int ntests = 0;
    int nfail  = 0;

    md_unit_iter dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    // Reference model in plain integer arithmetic.
    task automatic ref_md(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] rhi, output logic [31:0] rlo);
        longint      sx, sy, sq, sr;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        rhi = 32'h0;
        rlo = 32'h0;
        case (o)
            3'd0: begin p = 64'(sx * sy); rhi = p[63:32]; rlo = p[31:0]; end
            3'd1: begin p = {32'h0, x} * {32'h0, y}; rhi = p[63:32]; rlo = p[31:0]; end
            3'd2: begin
                if (y == 32'h0) begin rhi = x; rlo = 32'hFFFF_FFFF; end
                else begin
                    sq = sx / sy;
                    sr = sx % sy;
                    rlo = sq[31:0];
                    rhi = sr[31:0];
                end
            end
            3'd3: begin
                if (y == 32'h0) begin rhi = x; rlo = 32'hFFFF_FFFF; end
                else begin rlo = x / y; rhi = x % y; end
            end
            default: ;
        endcase
    endtask

    // Caller sits at a negedge; returns at the negedge of the done cycle (or on timeout).
    // If poke > 0, a stray MTLO start is driven during that RUN cycle.
    task automatic do_arith(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                            input int poke,
                            output int nbusy, output logic seen, output logic busy_at_done,
                            output logic done_first, output logic [31:0] ghi,
                            output logic [31:0] glo);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        done_first = done;
        nbusy = 0;
        seen = 1'b0;
        busy_at_done = 1'b1;
        for (int i = 0; i < 80 && !seen; i++) begin
            if (done) begin
                seen = 1'b1;
                busy_at_done = busy;
            end else begin
                if (busy) nbusy++;
                if (i == poke && poke > 0) begin
                    start = 1'b1; op = 3'd5; a = 32'hDEAD_BEEF; b = 32'h0;
                end
                @(negedge clk);
                start = 1'b0;
            end
        end
        ghi = hi;
        glo = lo;
    endtask

    task automatic check_op(input string name, input logic [2:0] o, input logic [31:0] x,
                            input logic [31:0] y, input int poke);
        int          nb;
        logic        seen, bad, df;
        logic [31:0] ghi, glo, ehi, elo;
        ref_md(o, x, y, ehi, elo);
        do_arith(o, x, y, poke, nb, seen, bad, df, ghi, glo);
        ntests++;
        if (!seen) begin
            nfail++;
            $display("FAIL %s timeout: done never seen (op=%0d a=%h b=%h)", name, o, x, y);
        end
        ntests++;
        if (nb !== 33) begin
            nfail++;
            $display("FAIL %s busy_cycles got %0d want 33", name, nb);
        end
        ntests++;
        if ({bad, df} !== 2'b00) begin
            nfail++;
            $display("FAIL %s busy_at_done/done_early got %b want 00", name, {bad, df});
        end
        ntests++;
        if ({ghi, glo} !== {ehi, elo}) begin
            nfail++;
            $display("FAIL %s op=%0d a=%h b=%h hi/lo got %h/%h want %h/%h",
                     name, o, x, y, ghi, glo, ehi, elo);
        end
    endtask

    task automatic test_reset();
        ntests++;
        if ({busy, done, hi, lo} !== 66'h0) begin
            nfail++;
            $display("FAIL reset busy/done/hi/lo got %b/%b/%h/%h want 0", busy, done, hi, lo);
        end
    endtask

    task automatic test_directed();
        check_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        ntests++;
        if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin
            nfail++;
            $display("FAIL multu_max_const got %h%h want fffffffe00000001", hi, lo);
        end
        check_op("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd5, 0);
        check_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 0);
        ntests++;
        if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            nfail++;
            $display("FAIL div_neg_const got %h/%h want ffffffff/fffffffd", hi, lo);
        end
        check_op("divu", 3'd3, 32'd100, 32'd7, 0);
        check_op("divu_zero", 3'd3, 32'h1234, 32'h0, 0);
        check_op("div_zero_neg", 3'd2, 32'h8765_4321, 32'h0, 0);
        check_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        ntests++;
        if ({hi, lo} !== 64'h0000_0000_8000_0000) begin
            nfail++;
            $display("FAIL div_ovf_const got %h/%h want 00000000/80000000", hi, lo);
        end
        check_op("mult_min", 3'd0, 32'h8000_0000, 32'h8000_0000, 0);
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [31:0] x, y;
        for (int k = 0; k < 24; k++) begin
            o = 3'($urandom_range(0, 3));
            x = $urandom;
            case ($urandom_range(0, 3))
                0: y = 32'($urandom_range(0, 15));
                1: y = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: y = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) x = 32'($urandom_range(0, 255));
            check_op("random", o, x, y, 0);
        end
    endtask

    task automatic test_ignored_start();
        // Stray MTLO during RUN must not disturb the result.
        check_op("ignored_start", 3'd3, 32'd100, 32'd7, 12);
    endtask

    task automatic test_mt_and_cancel();
        logic [31:0] x;
        start = 1'b1; op = 3'd4; a = 32'hAAAA_5555;
        @(negedge clk);
        ntests++;
        if ({hi, busy, done} !== {32'hAAAA_5555, 2'b00}) begin
            nfail++;
            $display("FAIL mthi hi/busy/done got %h/%b/%b want aaaa5555/0/0", hi, busy, done);
        end
        op = 3'd5; a = 32'h1;
        @(negedge clk);
        ntests++;
        if ({hi, lo, busy} !== {32'hAAAA_5555, 32'h1, 1'b0}) begin
            nfail++;
            $display("FAIL mtlo hi/lo/busy got %h/%h/%b want aaaa5555/00000001/0", hi, lo, busy);
        end
        // Op 6 and cancel+start in IDLE have no effect.
        op = 3'd6; a = 32'h5;
        @(negedge clk);
        op = 3'd4; cancel = 1'b1;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        ntests++;
        if ({hi, lo, busy} !== {32'hAAAA_5555, 32'h1, 1'b0}) begin
            nfail++;
            $display("FAIL idle_noop hi/lo/busy got %h/%h/%b want aaaa5555/00000001/0",
                     hi, lo, busy);
        end
        x = $urandom;
        start = 1'b1; op = 3'd1; a = x; b = 32'h3;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        // Now in the cycle where iteration 10 is performed.
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        ntests++;
        if ({busy, done, hi, lo} !== {2'b00, 32'hAAAA_5555, 32'h1}) begin
            nfail++;
            $display("FAIL cancel busy/done/hi/lo got %b/%b/%h/%h want 0/0/aaaa5555/00000001",
                     busy, done, hi, lo);
        end
        for (int i = 0; i < 40; i++) begin
            if (done || busy) begin
                ntests++;
                nfail++;
                $display("FAIL cancel_quiet cycle %0d busy/done got %b/%b want 0/0",
                         i, busy, done);
                break;
            end
            @(negedge clk);
        end
        ntests++;
        if ({hi, lo} !== {32'hAAAA_5555, 32'h1}) begin
            nfail++;
            $display("FAIL cancel_hold hi/lo got %h/%h want aaaa5555/00000001", hi, lo);
        end
    endtask

    task automatic test_rst_mid();
        start = 1'b1; op = 3'd1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        ntests++;
        if ({busy, done, hi, lo} !== 66'h0) begin
            nfail++;
            $display("FAIL rst_mid busy/done/hi/lo got %b/%b/%h/%h want 0", busy, done, hi, lo);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        ntests++;
        if ({busy, done, hi, lo} !== 66'h0) begin
            nfail++;
            $display("FAIL rst_after busy/done/hi/lo got %b/%b/%h/%h want 0",
                     busy, done, hi, lo);
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_random();
        test_ignored_start();
        @(negedge clk);
        test_mt_and_cancel();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/md_unit_iter.md
# md_unit_iter

Iterative multiply/divide unit with HI/LO registers that sits beside the EX stage of the five-stage pipelined CPU. EX issues MULT/MULTU/DIV/DIVU/MTHI/MTLO here. The unit's `busy` output drives the pipeline's stall logic for any following HI/LO access. Results are held in HI/LO and read back by MFHI/MFLO forwarding in ID/EX.

## Interface
- No parameters; data width fixed at 32 bits, iteration count fixed at 32.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  issue request from EX; sampled only when idle.
- `op`  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 are ignored.
- `a`  in  32  rs operand (EX_busA after forwarding).
- `b`  in  32  rt operand (EX_busB after forwarding).
- `cancel`  in  1  abort from the flush logic.
- `busy`  out  1  an operation is in flight; stall MFHI/MFLO/new md op in ID.
- `done`  out  1  one-cycle pulse after HI/LO are updated by an arithmetic op.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States: IDLE, RUN, FIX.
- Reset (async):
  - state is IDLE.
  - `hi`, `lo`, `busy`, `done`, counter and internal accumulators are all 0.
- IDLE, `start` with op 0–3:
  - Latch the operand magnitudes. Signed ops (0, 2) take two's-complement absolute values; unsigned ops take the raw values.
  - Latch the sign flags: quotient/product sign = a[31]^b[31]; remainder sign = a[31]. Both flags are 0 for unsigned ops.
  - Clear the 64-bit accumulator, set counter = 0, go to RUN.
- IDLE, `start` with op 4/5: write `a` into `hi` (op 4) or `lo` (op 5) at that edge. Stay IDLE; no busy, no done.
- IDLE, `start` with op 6/7: no effect.
- RUN: one iteration per cycle, counter 0..31; after the 32nd iteration go to FIX.
  - Multiply: radix-2 shift-add on a 64-bit product; unsigned 32×32 gives a 64-bit result.
  - Divide: restoring division; 32-bit quotient, 32-bit remainder.
- FIX:
  - Apply sign correction. Negate the product if its sign flag is set. Negate the quotient if its sign is set; negate the remainder if its sign is set.
  - Multiply result: {hi, lo} = 64-bit product.
  - Divide result: lo = quotient, hi = remainder.
  - Go to IDLE and pulse `done` on the following cycle.
- Divide by zero (b == 0 at start), signed or unsigned: lo = 32'hFFFF_FFFF, hi = a unchanged (raw, unsigned view). Still takes the full latency.
- Signed overflow 0x8000_0000 / −1: lo = 0x8000_0000, hi = 0. This falls out of the magnitude scheme with no special case.
- `start` while RUN/FIX: ignored. The pipeline must not issue while `busy`.
- `cancel`: in RUN or FIX, go to IDLE next edge; HI/LO unchanged; no done. In IDLE it has no effect, and it takes priority over a same-cycle `start`.
- `rst` mid-operation: immediate return to IDLE with all outputs 0.

## Timing
- Edge E0: `start` accepted.
- Edges E1..E32: iterations. E32 also transitions to FIX.
- Edge E33: HI/LO written, state goes IDLE.
- `busy` is registered: high from after E0 through E33, low after E33.
- `done` is high for exactly the cycle after E33.
- Total latency: 34 edges from accept to result visible.
- A new `start` may be accepted at E34, i.e. in the cycle `done` is high. That gives back-to-back throughput of 34 cycles per op.
- MTHI/MTLO: result visible the cycle after the accepting edge.
- `hi`/`lo` change only at E33, on an MTHI/MTLO accept, or on reset.

## Test plan
- MULTU a=0xFFFF_FFFF, b=0xFFFF_FFFF → after 34 edges: hi=0xFFFF_FFFE, lo=0x0000_0001, one-cycle `done`, `busy` high for exactly 33 cycles.
- MULT a=−3 (0xFFFF_FFFD), b=5 → hi=0xFFFF_FFFF, lo=0xFFFF_FFF1.
- DIV a=−7, b=2 → lo=0xFFFF_FFFD (−3), hi=0xFFFF_FFFF (−1).
- DIVU a=100, b=7 → lo=14, hi=2.
- Divide by zero: DIVU a=0x1234, b=0 → lo=0xFFFF_FFFF, hi=0x1234.
- DIV a=0x8000_0000, b=0xFFFF_FFFF → lo=0x8000_0000, hi=0.
- Control sequence:
  - MTHI a=0xAAAA_5555, then MTLO a=0x1 → hi/lo updated one cycle each with no busy.
  - Then start MULTU and assert `cancel` at iteration 10 → HI/LO keep 0xAAAA_5555 / 0x1, no `done`, `busy` low next cycle.
  - A second `start` issued during RUN is ignored.
  - `rst` pulsed mid-RUN clears all outputs to 0 asynchronously.
